// File: rtl/lz_pkg.sv
// Shared definitions for the leading-zero denormalizer and its lzc consumers.
// Default width, count-width helper and the per-stage pipeline record.
package lz_pkg;

  localparam int LZ_N = 32;

  function automatic int lz_cw(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int LZ_CW = lz_cw(LZ_N);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic             sticky;
    logic [LZ_CW-1:0] count;
    logic [LZ_N-1:0]  data;
  } lz_stage_t;

endpackage

// File: rtl/lz_shift_stage.sv
// One registered conditional right-shift stage of the denormalizer pipeline.
// Sticky tracking is present only when LZ_DENORM_STICKY_EN is defined.
module lz_shift_stage
  import lz_pkg::*;
#(
  parameter int N     = LZ_N,
  parameter int SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_adv,
  input  logic                 i_valid,
  input  logic                 i_err,
`ifdef LZ_DENORM_STICKY_EN
  input  logic                 i_sticky,
  output logic                 o_sticky,
`endif
  input  logic [$clog2(N)-1:0] i_count,
  input  logic [N-1:0]         i_data,
  output logic                 o_valid,
  output logic                 o_err,
  output logic [$clog2(N)-1:0] o_count,
  output logic [N-1:0]         o_data
);

  localparam int CB  = $clog2(N);
  localparam int BIT = $clog2(SHIFT);

  logic          w_take;
  logic [N-1:0]  w_data_nxt;
  logic          r_valid;
  logic          r_err;
  logic [CB-1:0] r_count;
  logic [N-1:0]  r_data;

  assign w_take     = i_count[BIT];
  assign w_data_nxt = w_take ? (i_data >> SHIFT) : i_data;

  // NOTE: data is reset along with valid so the output word reads 0 after reset;
  // all sequential state uses non-blocking assignment so stages update in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_data  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_err   <= i_err;
      r_count <= i_count;
      r_data  <= w_data_nxt;
    end
  end

`ifdef LZ_DENORM_STICKY_EN
  logic w_lost;
  logic r_sticky;

  assign w_lost = w_take & (|i_data[SHIFT-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (i_adv) begin
      r_sticky <= i_sticky | w_lost;
    end
  end

  assign o_sticky = r_sticky;
`endif

  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_count = r_count;
  assign o_data  = r_data;

endmodule

// File: rtl/lz_denorm.sv
// Denormalizer: logically right-shifts an MSB-aligned word by a leading-zero
// count through a log2(N)-stage pipeline. Optional out_sticky via LZ_DENORM_STICKY_EN.
module lz_denorm
  import lz_pkg::*;
#(
  parameter int N  = LZ_N,
  parameter int CW = lz_cw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_err
`ifdef LZ_DENORM_STICKY_EN
  ,
  output logic          out_sticky
`endif
);

  localparam int L = $clog2(N);

  logic         w_adv;
  logic         w_over;
  logic         w_full;
  logic         w_valid [0:L];
  logic         w_err   [0:L];
  logic [L-1:0] w_count [0:L];
  logic [N-1:0] w_data  [0:L];

  // A single stall signal freezes the whole pipe; only a full, unaccepted
  // output can block it, so there are no internal bubbles to collapse.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Counts of N and above clear the word up front; the shift stages then only
  // ever see the low log2(N) count bits.
  assign w_over     = in_count > CW'(N);
  assign w_full     = in_count >= CW'(N);
  assign w_valid[0] = in_valid;
  assign w_err[0]   = w_over;
  assign w_count[0] = in_count[L-1:0];
  assign w_data[0]  = w_full ? '0 : in_data;

`ifdef LZ_DENORM_STICKY_EN
  logic w_sticky [0:L];
  assign w_sticky[0] = w_full & ~w_over & (|in_data);
`endif

  for (genvar k = 0; k < L; k++) begin : g_stage
    lz_shift_stage #(
      .N     (N),
      .SHIFT (1 << k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_adv    (w_adv),
      .i_valid  (w_valid[k]),
      .i_err    (w_err[k]),
`ifdef LZ_DENORM_STICKY_EN
      .i_sticky (w_sticky[k]),
      .o_sticky (w_sticky[k+1]),
`endif
      .i_count  (w_count[k]),
      .i_data   (w_data[k]),
      .o_valid  (w_valid[k+1]),
      .o_err    (w_err[k+1]),
      .o_count  (w_count[k+1]),
      .o_data   (w_data[k+1])
    );
  end

  assign out_valid = w_valid[L];
  assign out_data  = w_data[L];
  assign out_err   = w_err[L];

`ifdef LZ_DENORM_STICKY_EN
  assign out_sticky = w_sticky[L] & ~w_err[L];
`endif

endmodule

// File: tb/tb_lz_denorm.sv
// Scoreboard bench for lz_denorm at N=32: expected words are queued on each
// accepted input and compared in order as results leave the pipeline.
module tb_lz_denorm;

  localparam int N  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_err;
`ifdef LZ_DENORM_STICKY_EN
  logic          out_sticky;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        sticky;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  lz_denorm #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_count   (in_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
`ifdef LZ_DENORM_STICKY_EN
    ,
    .out_sticky (out_sticky)
`endif
  );

  function automatic exp_t model(input logic [31:0] d, input logic [5:0] c);
    exp_t        e;
    logic [63:0] mask;
    e.err  = (c > 6'd32);
    e.data = (c >= 6'd32) ? 32'h0 : (d >> c);
    if (c > 6'd32) begin
      e.sticky = 1'b0;
    end else if (c == 6'd32) begin
      e.sticky = |d;
    end else begin
      mask     = (64'd1 << c) - 64'd1;
      e.sticky = |({32'h0, d} & mask);
    end
    return e;
  endfunction

  // Output monitor: every accepted result is checked against the queue head.
  always @(negedge clk) begin
    exp_t ex;
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_result: got data=%h err=%b, nothing expected", out_data, out_err);
      end else begin
        ex = q.pop_front();
        if (out_data !== ex.data || out_err !== ex.err) begin
          n_miss++;
          $display("FAIL result: got data=%h err=%b, want data=%h err=%b",
                   out_data, out_err, ex.data, ex.err);
        end
`ifdef LZ_DENORM_STICKY_EN
        n_vec++;
        if (out_sticky !== ex.sticky) begin
          n_miss++;
          $display("FAIL sticky: got %b, want %b (data=%h)", out_sticky, ex.sticky, ex.data);
        end
`endif
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] c);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_count = c;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      in_valid = 1'b0;
      $display("FAIL send_timeout: in_ready got 0, want 1 within 100 cycles");
    end else begin
      q.push_back(model(d, c));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_%s: %0d results outstanding, want 0", name, q.size());
    end
  endtask

  // Call right after the handshake edge; the first edge counts as cycle 1.
  task automatic wait_first_out(input string name);
    int lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != 5) begin
      n_miss++;
      $display("FAIL latency_%s: got %0d cycles, want 5", name, lat);
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    if (out_err !== 1'b0)   begin n_miss++; $display("FAIL reset_out_err: got %b, want 0", out_err); end
    if (out_data !== 32'h0) begin n_miss++; $display("FAIL reset_out_data: got %h, want 0", out_data); end
    if (in_ready !== 1'b1)  begin n_miss++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    align();
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    in_count = 6'd31;
    q.push_back(model(32'h8000_0000, 6'd31));
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL latency_in_ready: got %b, want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_first_out("single");
    drain("latency");
  endtask

  task automatic test_stream();
    int run = 0;
    int t   = 0;
    align();
    fork
      begin
        for (int k = 0; k <= 32; k++) send(32'hFFFF_FFFF, 6'(k));
        idle();
      end
      begin
        @(negedge clk);
        while (!out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        while (out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
      end
    join
    n_vec++;
    if (run != 33) begin
      n_miss++;
      $display("FAIL stream_run: got %0d consecutive results, want 33", run);
    end
    drain("stream");
  endtask

  task automatic test_bounds();
    align();
    send(32'hDEAD_BEEF, 6'd40);
    send(32'hF000_0000, 6'd4);
    send(32'h1234_5678, 6'd32);
    send(32'hA5A5_5A5A, 6'd0);
    send(32'h8000_0000, 6'd63);
    send(32'hFFFF_FFFF, 6'd33);
    idle();
    drain("bounds");
  endtask

  task automatic test_stall();
    align();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom, 6'($urandom_range(0, 40)));
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (in_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL stall_in_ready: got %b, want 0 (cycle %0d)", in_ready, i);
      end
      if (out_valid !== 1'b1) begin
        n_miss++;
        $display("FAIL stall_out_valid: got %b, want 1 (cycle %0d)", out_valid, i);
      end
      if (q.size() == 0 || out_data !== q[0].data) begin
        n_miss++;
        $display("FAIL stall_out_data: got %h, want head of queue (cycle %0d)", out_data, i);
      end
    end
    align();
    out_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_backpressure();
    align();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send($urandom, 6'($urandom_range(0, 40)));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            align();
          end
        end
        idle();
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_mid_reset();
    align();
    out_ready = 1'b0;
    send(32'hCAFE_0000, 6'd40);
    send(32'h0F0F_0F0F, 6'd3);
    send(32'h7777_7777, 6'd9);
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_vec += 2;
    if (out_valid !== 1'b1) begin n_miss++; $display("FAIL midrst_pre_valid: got %b, want 1", out_valid); end
    if (out_err !== 1'b1)   begin n_miss++; $display("FAIL midrst_pre_err: got %b, want 1", out_err); end
    #1 rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_out_valid: got %b, want 0", out_valid); end
    if (out_err !== 1'b0)   begin n_miss++; $display("FAIL midrst_out_err: got %b, want 0", out_err); end
    if (out_data !== 32'h0) begin n_miss++; $display("FAIL midrst_out_data: got %h, want 0", out_data); end
    if (in_ready !== 1'b1)  begin n_miss++; $display("FAIL midrst_in_ready: got %b, want 1", in_ready); end
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00FF_0000;
    in_count  = 6'd8;
    q.push_back(model(32'h00FF_0000, 6'd8));
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL postrst_in_ready: got %b, want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_first_out("post_reset");
    drain("mid_reset");
  endtask

`ifdef LZ_DENORM_STICKY_EN
  task automatic test_sticky();
    align();
    send(32'h8000_0003, 6'd2);
    send(32'h8000_0003, 6'd0);
    send(32'hFFFF_FFFF, 6'd40);
    send(32'h0000_0001, 6'd32);
    idle();
    drain("sticky");
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_bounds();
    test_stall();
    test_backpressure();
    test_mid_reset();
`ifdef LZ_DENORM_STICKY_EN
    test_sticky();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lz_denorm.md
LZ_DENORM -- requirements
Module: lz_denorm

Interface
REQ-001 Parameter N, default 32: data width; a power of two, 4..64.
REQ-002 Parameter CW, default $clog2(N)+1: count width, so a count of N is representable.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: in_data and in_count are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts input this cycle.
REQ-007 Port in_data, input, N: normalized word (MSB-aligned value).
REQ-008 Port in_count, input, CW: leading-zero count to restore, in the range 0..N.
REQ-009 Port out_valid, output, 1: the result is valid.
REQ-010 Port out_ready, input, 1: downstream accepts the result.
REQ-011 Port out_data, output, N: the denormalized word.
REQ-012 Port out_err, output, 1: in_count exceeded N for this result.

Function
REQ-013 The block SHALL compute out_data = in_data logically right-shifted by in_count, with zeros filled from the MSB side.
REQ-014 The shifter SHALL be a log2(N)-stage registered pipeline.
- Stage k shifts right by 2^k when count bit k is set; stages run from the LSB bit upward.
- Each stage carries its data, the remaining count bits, a valid bit and an err bit.
REQ-015 Latency SHALL be exactly log2(N) cycles from input handshake to out_valid, with no stalls; for N=32 this is 5 cycles.
REQ-016 A transfer SHALL occur only when valid && ready are both high on the same edge, at either port.
REQ-017 Pipeline advance SHALL use a single global enable, adv = out_ready || !out_valid, and in_ready SHALL equal adv.
REQ-018 When adv is low, every stage SHALL hold its contents, and out_data and out_valid SHALL stay stable.
REQ-019 When adv is high and in_valid is low, a bubble (valid=0) SHALL enter stage 0.
REQ-020 in_count == N SHALL produce out_data = 0 with out_err = 0.
REQ-021 in_count > N SHALL produce out_data = 0 with out_err = 1.
REQ-022 in_count == 0 SHALL pass in_data unchanged.
REQ-023 Back-to-back inputs SHALL give a throughput of one result per cycle while out_ready is held high.
REQ-024 Results SHALL leave in order; none SHALL be dropped or duplicated under any pattern of out_ready.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear every stage valid bit, out_valid and out_err, at any time including mid-operation.
- Data registers are don't-care after reset; out_data SHALL read 0 after reset.
- In-flight results are discarded.
REQ-026 in_ready SHALL be 1 during and after reset, because out_valid is 0.
REQ-027 The first input SHALL be accepted on the first clock edge after rst_n deasserts.

Configuration
REQ-028 Macro LZ_DENORM_STICKY_EN SHALL control the sticky output.
- Defined: the block adds output port out_sticky (1 bit), the OR of all bits shifted out; it is 1 on any nonzero loss, forced 0 when out_err is set, and reset to 0.
- Undefined: the port and its pipeline bits are absent; all other behaviour is identical.

Structure
REQ-029 Shared package lz_pkg SHALL hold:
- the default width constant LZ_N = 32;
- the function lz_cw(n) returning $clog2(n)+1;
- the typedef lz_stage_t {valid, err, sticky, count, data}, also used by lzc consumers.
REQ-030 A single sub-module lz_shift_stage SHALL implement one registered conditional shift stage.
- Parameters: N and SHIFT.
- Behaviour: hold on !adv, asynchronous reset of valid.
- It is instantiated log2(N) times under a generate loop.

Verification
REQ-031 in_data=0x8000_0000, in_count=31 -> out_data=0x0000_0001, out_err=0, 5 cycles later.
REQ-032 Stream counts 0,1,2,...,32 of 0xFFFF_FFFF back-to-back with out_ready=1 -> 33 consecutive results 0xFFFF_FFFF>>k, ending in 0; no gaps.
REQ-033 in_count=40 -> out_data=0, out_err=1; next input count=4 on 0xF000_0000 -> 0x0F00_0000, out_err=0.
REQ-034 Hold out_ready=0 for 10 cycles with the pipeline full -> in_ready=0 and out_data stable; then release it -> all 5 results delivered in order.
REQ-035 Assert rst_n low mid-stream with 3 results in flight -> out_valid=0 immediately, no stale result after release.
REQ-036 (STICKY_EN) in_data=0x8000_0003, count=2 -> out_data=0x2000_0000, out_sticky=1; count=0 -> out_sticky=0.
